// File: rtl/uart_tx_serializer.sv
// UART transmitter: pops 9-bit words from an upstream FIFO, sends start/data/stop; start bit leaves 2 cycles after the pop.
// Backpressure: at most one word in flight; the FIFO is popped only while idle, so back-to-back frames are 2 idle cycles apart.
module uart_tx_serializer #(
    parameter int NINE_BIT  = 0,
    parameter int STOP_BITS = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_fifo_rd_en,
    input  logic [8:0]  i_fifo_rd_data,
    input  logic        i_fifo_rd_valid,
    input  logic        i_fifo_empty,
    input  logic [15:0] i_baud_div,
    output logic        o_tx,
    output logic        o_busy
);

    localparam logic [3:0] LAST_DATA = (NINE_BIT != 0) ? 4'd8 : 4'd7;
    localparam logic [3:0] LAST_STOP = (STOP_BITS == 2) ? 4'd1 : 4'd0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        STOP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic [15:0] div_q;
    logic [15:0] div_nxt;
    logic [3:0]  idx;
    logic [3:0]  idx_nxt;
    logic [8:0]  shreg;
    logic [8:0]  shreg_nxt;
    logic        tx_nxt;
    logic [15:0] div_eff;

    assign div_eff      = (i_baud_div == 16'd0) ? 16'd1 : i_baud_div;
    assign o_fifo_rd_en = (state == IDLE) && !i_fifo_empty && !i_rst;
    assign o_busy       = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= 16'd0;
            idx   <= 4'd0;
            div_q <= 16'd0;
            shreg <= 9'd0;
            o_tx  <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            div_q <= div_nxt;
            shreg <= shreg_nxt;
            o_tx  <= tx_nxt;
        end
    end

    // cnt counts down the remaining cycles of the bit currently on the line;
    // o_tx is updated on the same edge as the state so each bit lasts div_q cycles.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        div_nxt   = div_q;
        shreg_nxt = shreg;
        tx_nxt    = o_tx;
        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (!i_fifo_empty) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (i_fifo_rd_valid) begin
                    shreg_nxt = i_fifo_rd_data;
                    div_nxt   = div_eff;
                    cnt_nxt   = div_eff - 16'd1;
                    idx_nxt   = 4'd0;
                    tx_nxt    = 1'b0;
                    state_nxt = START;
                end else begin
                    tx_nxt    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            START: begin
                if (cnt == 16'd0) begin
                    tx_nxt    = shreg[0];
                    shreg_nxt = {1'b0, shreg[8:1]};
                    cnt_nxt   = div_q - 16'd1;
                    idx_nxt   = 4'd0;
                    state_nxt = DATA;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            DATA: begin
                if (cnt == 16'd0) begin
                    cnt_nxt = div_q - 16'd1;
                    if (idx == LAST_DATA) begin
                        tx_nxt    = 1'b1;
                        idx_nxt   = 4'd0;
                        state_nxt = STOP;
                    end else begin
                        tx_nxt    = shreg[0];
                        shreg_nxt = {1'b0, shreg[8:1]};
                        idx_nxt   = idx + 4'd1;
                    end
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            STOP: begin
                tx_nxt = 1'b1;
                if (cnt == 16'd0) begin
                    if (idx == LAST_STOP) begin
                        idx_nxt   = 4'd0;
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt = idx + 4'd1;
                        cnt_nxt = div_q - 16'd1;
                    end
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            default: begin
                tx_nxt    = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 SHALL have parameter NINE_BIT, default 0: 1 = transmit fetched bit 8 as a ninth data bit; 0 = ignore bit 8.
REQ-002 SHALL have parameter STOP_BITS, default 1: stop-bit count, legal values 1 or 2.
REQ-003 SHALL have port i_clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port o_fifo_rd_en  output  1  one-cycle pop request to the upstream FIFO.
REQ-006 SHALL have port i_fifo_rd_data  input  9  popped word; valid when i_fifo_rd_valid=1.
REQ-007 SHALL have port i_fifo_rd_valid  input  1  asserted one cycle after an accepted pop.
REQ-008 SHALL have port i_fifo_empty  input  1  upstream FIFO holds no words.
REQ-009 SHALL have port i_baud_div  input  16  clocks per bit period; 0 is treated as 1.
REQ-010 SHALL have port o_tx  output  1  serial line, registered, idle high.
REQ-011 SHALL have port o_busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 SHALL implement states IDLE, FETCH, START, DATA, STOP.
REQ-013 SHALL drive o_fifo_rd_en = (state==IDLE) && ~i_fifo_empty && ~i_rst, combinationally; IDLE->FETCH on the same edge.
REQ-014 SHALL, in FETCH with i_fifo_rd_valid=1, latch i_fifo_rd_data[8:0] and the effective divisor, go to START, and drive o_tx=0 from the next cycle.
REQ-015 SHALL, in FETCH with i_fifo_rd_valid=0, return to IDLE with no line activity (spurious pop tolerated).
REQ-016 SHALL hold every bit (start, data, stop) on o_tx for exactly the latched divisor count of cycles.
REQ-017 SHALL send data LSB first: 8 bits when NINE_BIT=0; 9 bits (bit 8 last) when NINE_BIT=1.
REQ-018 SHALL send STOP_BITS stop periods at o_tx=1, then enter IDLE.
REQ-019 SHALL ignore changes on i_baud_div within a frame; the new value applies from the next FETCH latch.
REQ-020 SHALL use a 16-bit down-counter for the bit period and a 4-bit bit index; no wrap beyond frame length.
REQ-021 SHALL, for back-to-back frames, leave exactly 2 idle-high cycles between the last stop cycle and the next start bit (IDLE pop cycle + FETCH cycle).
REQ-022 SHALL never assert o_fifo_rd_en outside IDLE, so at most one word is in flight.

Reset
REQ-023 SHALL, while i_rst=1, force state=IDLE, o_tx=1, o_busy=0, o_fifo_rd_en=0, counters=0.
REQ-024 SHALL, on reset mid-frame, abort the frame, drive o_tx=1 from the cycle after i_rst is sampled, and discard the latched word.
REQ-025 SHALL issue the first pop no earlier than the first cycle with i_rst=0.

Verification
REQ-026 SHALL cover: div=4, word 0x055 -> o_tx low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles; frame 40 cycles; one rd_en pulse.
REQ-027 SHALL cover: two words 0x0A5, 0x03C queued, div=2 -> two 20-cycle frames separated by exactly 2 high cycles; exactly 2 rd_en pulses.
REQ-028 SHALL cover: div=0, NINE_BIT=1, STOP_BITS=2, word 0x1A5 -> 12-cycle frame, data 1,0,1,0,0,1,0,1,1, two stop cycles.
REQ-029 SHALL cover: i_rst pulsed during data bit 3 -> o_tx=1 next cycle, o_busy=0, no rd_en during reset; next queued word sent cleanly afterward.
REQ-030 SHALL cover: i_fifo_empty held 1 -> o_fifo_rd_en never asserts, o_tx stays 1; i_baud_div changed 4->8 mid-frame -> current frame keeps 4-cycle bits, next frame uses 8.
